// File: rtl/digit_pkg.sv
// Shared definitions for the BCD digit combiner: FSM state encoding and BCD digit limit.
package digit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/digit_mac.sv
// Combinational multiply-by-ten-and-add: acc*10 + digit, widened by 4 bits so nothing truncates.
module digit_mac #(
  parameter int BIT_WIDTH = 7
) (
  input  logic [BIT_WIDTH-1:0] i_acc,
  input  logic [3:0]           i_digit,
  output logic [BIT_WIDTH+3:0] o_acc_next
);

  logic [BIT_WIDTH+3:0] w_acc_ext;
  logic [BIT_WIDTH+3:0] w_digit_ext;

  assign w_acc_ext   = {4'b0000, i_acc};
  assign w_digit_ext = (BIT_WIDTH+4)'(i_digit);
  // x*10 as x*8 + x*2
  assign o_acc_next  = (w_acc_ext << 3) + (w_acc_ext << 1) + w_digit_ext;

endmodule

// File: rtl/digit_combiner.sv
// Collects BCD digits MSD-first into a binary value, committing on request or after MAX_DIGITS digits.
module digit_combiner
  import digit_pkg::*;
#(
  parameter int BIT_WIDTH  = 7,
  parameter int MAX_DIGITS = 2,
  parameter int MAX_VALUE  = 99
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [3:0]                         digit_in,
  input  logic                               digit_valid,
  output logic                               digit_ready,
  input  logic                               commit,
  input  logic                               clear,
  output logic [BIT_WIDTH-1:0]               count_data,
  output logic                               data_valid,
  output logic                               error,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0]          LAST_IDX = CW'(MAX_DIGITS - 1);
  localparam logic [BIT_WIDTH+3:0]   MAX_EXT  = (BIT_WIDTH+4)'(MAX_VALUE);

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_digit_count;
  logic [BIT_WIDTH-1:0] r_count_data;
  logic                 r_data_valid;
  logic                 r_error;

  logic [BIT_WIDTH+3:0] w_acc_next;
  logic                 w_accept;
  logic                 w_bad_digit;
  logic                 w_overflow;
  logic                 w_last;
  logic                 w_ready;

  digit_mac #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_mac (
    .i_acc      (r_acc),
    .i_digit    (digit_in),
    .o_acc_next (w_acc_next)
  );

  assign w_ready     = (r_state != ERROR) && !r_data_valid;
  assign w_accept    = digit_valid && w_ready;
  assign w_bad_digit = digit_in > BCD_MAX;
  assign w_overflow  = w_acc_next > MAX_EXT;
  assign w_last      = r_digit_count == LAST_IDX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_digit_count <= '0;
      r_count_data  <= '0;
      r_data_valid  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (clear) begin
        r_state       <= IDLE;
        r_acc         <= '0;
        r_digit_count <= '0;
        r_error       <= 1'b0;
      end else begin
        case (r_state)
          IDLE, ACCUM: begin
            if (w_accept) begin
              if (w_bad_digit || w_overflow) begin
                r_state <= ERROR;
                r_error <= 1'b1;
              end else if (commit || w_last) begin
                // A good digit arriving with commit is folded into the committed value
                r_count_data  <= w_acc_next[BIT_WIDTH-1:0];
                r_data_valid  <= 1'b1;
                r_acc         <= '0;
                r_digit_count <= '0;
                r_state       <= IDLE;
              end else begin
                r_acc         <= w_acc_next[BIT_WIDTH-1:0];
                r_digit_count <= r_digit_count + 1'b1;
                r_state       <= ACCUM;
              end
            end else if (commit && (r_state == ACCUM)) begin
              r_count_data  <= r_acc;
              r_data_valid  <= 1'b1;
              r_acc         <= '0;
              r_digit_count <= '0;
              r_state       <= IDLE;
            end
          end
          default: begin
            r_state <= ERROR;
          end
        endcase
      end
    end
  end

  assign digit_ready = w_ready;
  assign count_data  = r_count_data;
  assign data_valid  = r_data_valid;
  assign error       = r_error;
  assign digit_count = r_digit_count;

endmodule

// File: tb/tb_digit_combiner.sv
// Directed bench for digit_combiner: default instance A plus a 3-digit/127 instance B.
module tb_digit_combiner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a_digit = '0;
  logic       a_valid = 1'b0, a_commit = 1'b0, a_clear = 1'b0;
  logic       a_ready, a_dv, a_err;
  logic [6:0] a_data;
  logic [1:0] a_cnt;

  logic [3:0] b_digit = '0;
  logic       b_valid = 1'b0, b_commit = 1'b0, b_clear = 1'b0;
  logic       b_ready, b_dv, b_err;
  logic [6:0] b_data;
  logic [1:0] b_cnt;

  int checks = 0;
  int errors = 0;

  digit_combiner u_dut_a (
    .clk(clk), .rst_n(rst_n), .digit_in(a_digit), .digit_valid(a_valid),
    .digit_ready(a_ready), .commit(a_commit), .clear(a_clear),
    .count_data(a_data), .data_valid(a_dv), .error(a_err), .digit_count(a_cnt)
  );

  digit_combiner #(.BIT_WIDTH(7), .MAX_DIGITS(3), .MAX_VALUE(127)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .digit_in(b_digit), .digit_valid(b_valid),
    .digit_ready(b_ready), .commit(b_commit), .clear(b_clear),
    .count_data(b_data), .data_valid(b_dv), .error(b_err), .digit_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (a_data !== 7'd0) begin errors++; $display("FAIL rst_hold_data: got %0d expected 0", a_data); end
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL rst_hold_dv: got %0d expected 0", a_dv); end
    rst_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d expected 1", a_ready); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_error: got %0d expected 0", a_err); end
    checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", a_cnt); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_b: got %0d expected 1", b_ready); end
    tick();
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_cyc1: got %0d expected 1", a_ready); end
  endtask

  task automatic test_auto_commit();
    a_digit = 4'd4; a_valid = 1'b1;
    tick();
    checks++; if (a_cnt !== 2'd1) begin errors++; $display("FAIL auto_cnt1: got %0d expected 1", a_cnt); end
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL auto_dv_early: got %0d expected 0", a_dv); end
    a_digit = 4'd2;
    tick();
    a_valid = 1'b0;
    checks++; if (a_data !== 7'd42) begin errors++; $display("FAIL auto_data: got %0d expected 42", a_data); end
    checks++; if (a_dv !== 1'b1) begin errors++; $display("FAIL auto_dv: got %0d expected 1", a_dv); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL auto_ready: got %0d expected 0", a_ready); end
    checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL auto_cnt0: got %0d expected 0", a_cnt); end
    tick();
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL auto_dv_pulse: got %0d expected 0", a_dv); end
    checks++; if (a_data !== 7'd42) begin errors++; $display("FAIL auto_hold: got %0d expected 42", a_data); end
  endtask

  task automatic test_commit();
    a_digit = 4'd7; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_commit = 1'b1;
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL commit_dv_early: got %0d expected 0", a_dv); end
    tick();
    checks++; if (a_data !== 7'd7) begin errors++; $display("FAIL commit_data: got %0d expected 7", a_data); end
    checks++; if (a_dv !== 1'b1) begin errors++; $display("FAIL commit_dv: got %0d expected 1", a_dv); end
    tick();
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL commit_idle_dv: got %0d expected 0", a_dv); end
    tick();
    a_commit = 1'b0;
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL commit_idle_dv2: got %0d expected 0", a_dv); end
    checks++; if (a_data !== 7'd7) begin errors++; $display("FAIL commit_hold: got %0d expected 7", a_data); end
  endtask

  task automatic test_commit_with_digit();
    b_digit = 4'd1; b_valid = 1'b1;
    tick();
    b_digit = 4'd5; b_commit = 1'b1;
    tick();
    b_valid = 1'b0; b_commit = 1'b0;
    checks++; if (b_data !== 7'd15) begin errors++; $display("FAIL cwd_data: got %0d expected 15", b_data); end
    checks++; if (b_dv !== 1'b1) begin errors++; $display("FAIL cwd_dv: got %0d expected 1", b_dv); end
    checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL cwd_cnt: got %0d expected 0", b_cnt); end
    tick();
  endtask

  task automatic test_bad_digit();
    a_digit = 4'hA; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL bad_error: got %0d expected 1", a_err); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bad_ready: got %0d expected 0", a_ready); end
    checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL bad_cnt: got %0d expected 0", a_cnt); end
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    tick();
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL bad_commit_dv: got %0d expected 0", a_dv); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %0d expected 1", a_err); end
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL bad_clear_err: got %0d expected 0", a_err); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bad_clear_ready: got %0d expected 1", a_ready); end
    checks++; if (a_data !== 7'd7) begin errors++; $display("FAIL bad_clear_data: got %0d expected 7", a_data); end
  endtask

  task automatic test_overflow();
    b_valid = 1'b1;
    b_digit = 4'd1; tick();
    b_digit = 4'd2; tick();
    checks++; if (b_cnt !== 2'd2) begin errors++; $display("FAIL ovf_cnt: got %0d expected 2", b_cnt); end
    b_digit = 4'd8; tick();
    b_valid = 1'b0;
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL ovf_error: got %0d expected 1", b_err); end
    checks++; if (b_dv !== 1'b0) begin errors++; $display("FAIL ovf_dv: got %0d expected 0", b_dv); end
    tick();
    checks++; if (b_dv !== 1'b0) begin errors++; $display("FAIL ovf_dv2: got %0d expected 0", b_dv); end
    checks++; if (b_data !== 7'd15) begin errors++; $display("FAIL ovf_hold: got %0d expected 15", b_data); end
    b_clear = 1'b1; tick(); b_clear = 1'b0;
    b_valid = 1'b1;
    b_digit = 4'd1; tick();
    b_digit = 4'd2; tick();
    b_digit = 4'd7; tick();
    b_valid = 1'b0;
    checks++; if (b_data !== 7'd127) begin errors++; $display("FAIL max_data: got %0d expected 127", b_data); end
    checks++; if (b_dv !== 1'b1) begin errors++; $display("FAIL max_dv: got %0d expected 1", b_dv); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL max_error: got %0d expected 0", b_err); end
    tick();
  endtask

  task automatic test_clear_priority();
    a_digit = 4'd5; a_valid = 1'b1; a_commit = 1'b1; a_clear = 1'b1;
    tick();
    a_valid = 1'b0; a_commit = 1'b0; a_clear = 1'b0;
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL clr_dv: got %0d expected 0", a_dv); end
    checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", a_cnt); end
    checks++; if (a_data !== 7'd7) begin errors++; $display("FAIL clr_data: got %0d expected 7", a_data); end
    a_digit = 4'd3; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    checks++; if (a_data !== 7'd3) begin errors++; $display("FAIL clr_acc_zero: got %0d expected 3", a_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    a_valid = 1'b1;
    a_digit = 4'd1; tick();
    a_digit = 4'd2; tick();
    a_digit = 4'd8;
    checks++; if (a_data !== 7'd12) begin errors++; $display("FAIL b2b_data: got %0d expected 12", a_data); end
    tick();
    checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL b2b_blocked: got %0d expected 0", a_cnt); end
    tick();
    checks++; if (a_cnt !== 2'd1) begin errors++; $display("FAIL b2b_accept: got %0d expected 1", a_cnt); end
    a_digit = 4'd1; tick();
    a_valid = 1'b0;
    checks++; if (a_data !== 7'd81) begin errors++; $display("FAIL b2b_data2: got %0d expected 81", a_data); end
    tick();
  endtask

  task automatic test_mid_reset();
    a_digit = 4'd9; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (a_cnt !== 2'd0) begin errors++; $display("FAIL mrst_cnt: got %0d expected 0", a_cnt); end
    checks++; if (a_data !== 7'd0) begin errors++; $display("FAIL mrst_data: got %0d expected 0", a_data); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (a_dv !== 1'b0) begin errors++; $display("FAIL mrst_dv: got %0d expected 0", a_dv); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %0d expected 1", a_ready); end
  endtask

  initial begin
    test_reset();
    test_auto_commit();
    test_commit();
    test_commit_with_digit();
    test_bad_digit();
    test_overflow();
    test_clear_priority();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
